// File: rtl/trainerror_sb_arbiter_if.sv
// Sideband transmit sharing bus between the TRAINERROR TX/RX handshake FSMs and the SB encoder.
// master = requester/SB side that drives the i_* signals, slave = the arbiter.
interface trainerror_sb_arbiter_if #(
  parameter int SB_MSG_WIDTH = 4
);
  logic                    i_trainerror_en;
  logic                    i_tx_valid;
  logic [SB_MSG_WIDTH-1:0] i_tx_msg;
  logic                    i_rx_valid;
  logic [SB_MSG_WIDTH-1:0] i_rx_msg;
  logic                    i_sb_busy;
  logic                    o_sb_valid;
  logic [SB_MSG_WIDTH-1:0] o_sb_msg;
  logic                    o_tx_done;
  logic                    o_rx_done;
  logic                    o_grant_tx;
  logic                    o_grant_rx;
  logic                    o_timeout;

  modport master (
    output i_trainerror_en, i_tx_valid, i_tx_msg, i_rx_valid, i_rx_msg, i_sb_busy,
    input  o_sb_valid, o_sb_msg, o_tx_done, o_rx_done, o_grant_tx, o_grant_rx, o_timeout
  );

  modport slave (
    input  i_trainerror_en, i_tx_valid, i_tx_msg, i_rx_valid, i_rx_msg, i_sb_busy,
    output o_sb_valid, o_sb_msg, o_tx_done, o_rx_done, o_grant_tx, o_grant_rx, o_timeout
  );
endinterface

// File: rtl/trainerror_sb_arbiter.sv
// Round-robin arbiter sharing the SB transmit message port between the TRAINERROR TX and RX FSMs.
// Optional grant watchdog enabled by defining TRAINERROR_ARB_TIMEOUT_EN.
module trainerror_sb_arbiter #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  trainerror_sb_arbiter_if.slave sb
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SENDING,
    ST_RELEASE
  } state_e;

  state_e                  state_q, state_d;
  logic                    busy_q;
  logic                    last_rx_q, last_rx_d;
  logic                    sb_valid_q, sb_valid_d;
  logic [SB_MSG_WIDTH-1:0] sb_msg_q, sb_msg_d;
  logic                    grant_tx_q, grant_tx_d;
  logic                    grant_rx_q, grant_rx_d;
  logic                    tx_done_q, tx_done_d;
  logic                    rx_done_q, rx_done_d;

  logic busy_fall;
  logic granted_valid;
  logic pick_tx;
  logic to_hit;

  assign busy_fall     = busy_q & ~sb.i_sb_busy;
  assign granted_valid = (grant_tx_q & sb.i_tx_valid) | (grant_rx_q & sb.i_rx_valid);
  // last_rx_q set means RX won the previous arbitration, so TX takes a tie
  assign pick_tx       = sb.i_tx_valid & (~sb.i_rx_valid | last_rx_q);

`ifdef TRAINERROR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             owned_q, owned_d;

  assign owned_q = (state_q == ST_GRANT) | (state_q == ST_SENDING);
  assign owned_d = (state_d == ST_GRANT) | (state_d == ST_SENDING);
  // Fires on the edge where the count would reach TIMEOUT_CYCLES
  assign to_hit    = owned_q & (cnt_q == CNT_LAST);
  assign cnt_d     = (owned_q & owned_d) ? cnt_q + CNT_W'(1) : '0;
  assign timeout_d = to_hit & sb.i_trainerror_en;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign sb.o_timeout = timeout_q;
`else
  assign to_hit = 1'b0;
  // Watchdog absent: output is constant low for any legal limit
  assign sb.o_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d    = state_q;
    last_rx_d  = last_rx_q;
    sb_valid_d = sb_valid_q;
    sb_msg_d   = sb_msg_q;
    grant_tx_d = grant_tx_q;
    grant_rx_d = grant_rx_q;
    tx_done_d  = 1'b0;
    rx_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sb.i_trainerror_en && !sb.i_sb_busy && (sb.i_tx_valid || sb.i_rx_valid)) begin
          state_d    = ST_GRANT;
          sb_valid_d = 1'b1;
          grant_tx_d = pick_tx;
          grant_rx_d = ~pick_tx;
          last_rx_d  = ~pick_tx;
          sb_msg_d   = pick_tx ? sb.i_tx_msg : sb.i_rx_msg;
        end
      end
      ST_GRANT: begin
        if (to_hit) begin
          state_d    = ST_RELEASE;
          sb_valid_d = 1'b0;
          grant_tx_d = 1'b0;
          grant_rx_d = 1'b0;
        end else if (sb.i_sb_busy) begin
          state_d = ST_SENDING;
        end else if (!granted_valid) begin
          state_d    = ST_IDLE;
          sb_valid_d = 1'b0;
          grant_tx_d = 1'b0;
          grant_rx_d = 1'b0;
        end
      end
      ST_SENDING: begin
        if (to_hit) begin
          state_d    = ST_RELEASE;
          sb_valid_d = 1'b0;
          grant_tx_d = 1'b0;
          grant_rx_d = 1'b0;
        end else if (busy_fall) begin
          state_d    = ST_RELEASE;
          sb_valid_d = 1'b0;
          tx_done_d  = grant_tx_q;
          rx_done_d  = grant_rx_q;
          grant_tx_d = 1'b0;
          grant_rx_d = 1'b0;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Leaving TRAINERROR aborts any transfer; arbitration history is kept
    if (!sb.i_trainerror_en) begin
      state_d    = ST_IDLE;
      sb_valid_d = 1'b0;
      grant_tx_d = 1'b0;
      grant_rx_d = 1'b0;
      tx_done_d  = 1'b0;
      rx_done_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      last_rx_q  <= 1'b1;
      sb_valid_q <= 1'b0;
      sb_msg_q   <= '0;
      grant_tx_q <= 1'b0;
      grant_rx_q <= 1'b0;
      tx_done_q  <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= sb.i_sb_busy;
      last_rx_q  <= last_rx_d;
      sb_valid_q <= sb_valid_d;
      sb_msg_q   <= sb_msg_d;
      grant_tx_q <= grant_tx_d;
      grant_rx_q <= grant_rx_d;
      tx_done_q  <= tx_done_d;
      rx_done_q  <= rx_done_d;
    end
  end

  assign sb.o_sb_valid = sb_valid_q;
  assign sb.o_sb_msg   = sb_msg_q;
  assign sb.o_grant_tx = grant_tx_q;
  assign sb.o_grant_rx = grant_rx_q;
  assign sb.o_tx_done  = tx_done_q;
  assign sb.o_rx_done  = rx_done_q;

endmodule

// File: tb/tb_trainerror_sb_arbiter.sv
// Directed bench for trainerror_sb_arbiter; expectations are hand-derived cycle by cycle.
module tb_trainerror_sb_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  trainerror_sb_arbiter_if #(.SB_MSG_WIDTH(4)) bus ();

  trainerror_sb_arbiter #(
    .SB_MSG_WIDTH  (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .sb     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // Outputs packed as {valid, grant_tx, grant_rx, tx_done, rx_done, timeout}
  function automatic logic [7:0] flags();
    return {2'b00, bus.o_sb_valid, bus.o_grant_tx, bus.o_grant_rx,
            bus.o_tx_done, bus.o_rx_done, bus.o_timeout};
  endfunction

  // Busy rises in GRANT, falls the next cycle; done is expected after the second edge
  task automatic transfer();
    bus.i_sb_busy = 1'b1;
    tick();
    bus.i_sb_busy = 1'b0;
    tick();
  endtask

  logic held;

  initial begin
    rst_n               = 1'b0;
    bus.i_trainerror_en = 1'b0;
    bus.i_tx_valid      = 1'b0;
    bus.i_tx_msg        = 4'h0;
    bus.i_rx_valid      = 1'b0;
    bus.i_rx_msg        = 4'h0;
    bus.i_sb_busy       = 1'b0;
    tick();
    tick();
    check("reset_flags", flags(), 8'h00);
    check("reset_msg", 8'(bus.o_sb_msg), 8'h0);
    rst_n               = 1'b1;
    bus.i_trainerror_en = 1'b1;

    // TX only, msg A, busy up two cycles after valid, down three cycles later
    bus.i_tx_valid = 1'b1;
    bus.i_tx_msg   = 4'hA;
    tick();
    check("tx_grant_flags", flags(), 8'b0011_0000);
    check("tx_grant_msg", 8'(bus.o_sb_msg), 8'hA);
    bus.i_tx_msg = 4'h1;
    tick();
    check("tx_grant_hold", flags(), 8'b0011_0000);
    bus.i_sb_busy = 1'b1;
    tick();
    tick();
    tick();
    check("tx_sending", flags(), 8'b0011_0000);
    check("tx_sending_msg", 8'(bus.o_sb_msg), 8'hA);
    bus.i_sb_busy = 1'b0;
    tick();
    check("tx_done_pulse", flags(), 8'b0000_0100);
    check("tx_done_msg", 8'(bus.o_sb_msg), 8'hA);
    bus.i_tx_valid = 1'b0;
    tick();
    check("tx_release", flags(), 8'h00);
    tick();
    check("tx_idle", flags(), 8'h00);

    // Round-robin ties after a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n          = 1'b1;
    bus.i_tx_valid = 1'b1;
    bus.i_tx_msg   = 4'h3;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_msg   = 4'hE;
    tick();
    check("tie1_flags", flags(), 8'b0011_0000);
    check("tie1_msg", 8'(bus.o_sb_msg), 8'h3);
    transfer();
    check("tie1_done", flags(), 8'b0000_0100);
    tick();
    tick();
    check("tie2_flags", flags(), 8'b0010_1000);
    check("tie2_msg", 8'(bus.o_sb_msg), 8'hE);
    transfer();
    check("tie2_done", flags(), 8'b0000_0010);
    tick();
    tick();
    check("tie3_flags", flags(), 8'b0011_0000);
    check("tie3_msg", 8'(bus.o_sb_msg), 8'h3);
    transfer();
    check("tie3_done", flags(), 8'b0000_0100);
    bus.i_tx_valid = 1'b0;
    bus.i_rx_valid = 1'b0;
    tick();
    tick();

    // Busy already high: no grant until it drops, busy fall in IDLE gives no done
    bus.i_sb_busy  = 1'b1;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_msg   = 4'h5;
    tick();
    check("busy_block1", flags(), 8'h00);
    tick();
    check("busy_block2", flags(), 8'h00);
    check("busy_block_msg", 8'(bus.o_sb_msg), 8'h3);
    bus.i_sb_busy = 1'b0;
    tick();
    check("busy_then_grant", flags(), 8'b0010_1000);
    check("busy_then_msg", 8'(bus.o_sb_msg), 8'h5);
    transfer();
    check("busy_rx_done", flags(), 8'b0000_0010);
    bus.i_rx_valid = 1'b0;
    tick();
    tick();

    // TRAINERROR exit while SENDING
    bus.i_tx_valid = 1'b1;
    bus.i_tx_msg   = 4'h7;
    tick();
    check("en_grant", flags(), 8'b0011_0000);
    bus.i_sb_busy = 1'b1;
    tick();
    bus.i_trainerror_en = 1'b0;
    tick();
    check("en_drop", flags(), 8'h00);
    bus.i_sb_busy  = 1'b0;
    bus.i_tx_valid = 1'b0;
    tick();
    check("en_drop_nodone", flags(), 8'h00);
    bus.i_trainerror_en = 1'b1;
    tick();

    // TX aborts in GRANT, pending RX granted from IDLE
    bus.i_tx_valid = 1'b1;
    bus.i_tx_msg   = 4'h9;
    tick();
    check("abort_grant", flags(), 8'b0011_0000);
    bus.i_tx_valid = 1'b0;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_msg   = 4'hC;
    tick();
    check("abort_drop", flags(), 8'h00);
    check("abort_msg_held", 8'(bus.o_sb_msg), 8'h9);
    tick();
    check("abort_rx_grant", flags(), 8'b0010_1000);
    check("abort_rx_msg", 8'(bus.o_sb_msg), 8'hC);
    transfer();
    check("abort_rx_done", flags(), 8'b0000_0010);
    bus.i_rx_valid = 1'b0;
    tick();
    tick();

    // Busy never rises
    bus.i_tx_valid = 1'b1;
    bus.i_tx_msg   = 4'h6;
    tick();
    check("wd_grant", flags(), 8'b0011_0000);
`ifdef TRAINERROR_ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    check("wd_before", flags(), 8'b0011_0000);
    tick();
    check("wd_fire", flags(), 8'b0000_0001);
    bus.i_tx_valid = 1'b0;
    tick();
    check("wd_pulse_end", flags(), 8'h00);
`else
    held = 1'b1;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (flags() != 8'b0011_0000) held = 1'b0;
    end
    check("wd_off_hold", 8'(held), 8'h1);
    bus.i_tx_valid      = 1'b0;
    bus.i_trainerror_en = 1'b0;
    tick();
    check("wd_off_exit", flags(), 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trainerror_sb_arbiter.md
Name: trainerror_sb_arbiter

Overview:
Shares the single sideband transmit message interface between the TRAINERROR TX-side and RX-side handshake FSMs.
- Arbitrates between the two requesters with round-robin priority.
- Latches the granted encoded message and drives it to the SB with a valid.
- Tracks SB busy and returns a one-cycle done pulse to the granted requester when busy falls.
- Sits between the TRAINERROR TX/RX FSMs and the SB encoder inside the LTSM TRAINERROR wrapper.

Parameters:
SB_MSG_WIDTH, 4, width of encoded SB message code
TIMEOUT_CYCLES, 1023, grant watchdog limit in cycles (used only with the optional feature)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset, sampled on rising i_clk
i_trainerror_en  in  1  TRAINERROR state active; low forces IDLE
i_tx_valid  in  1  TX FSM request
i_tx_msg  in  SB_MSG_WIDTH  TX FSM encoded message
i_rx_valid  in  1  RX FSM request
i_rx_msg  in  SB_MSG_WIDTH  RX FSM encoded message
i_sb_busy  in  1  SB transmitter busy
o_sb_valid  out  1  message valid to SB
o_sb_msg  out  SB_MSG_WIDTH  granted message to SB
o_tx_done  out  1  one-cycle pulse: TX message consumed
o_rx_done  out  1  one-cycle pulse: RX message consumed
o_grant_tx  out  1  TX currently owns SB
o_grant_rx  out  1  RX currently owns SB
o_timeout  out  1  one-cycle pulse on watchdog expiry (0 when feature off)

Behaviour:
- All outputs registered. Reset (i_rst_n=0 at a clock edge): all outputs 0, state IDLE, busy_q=0, last_grant=RX so TX wins the first tie.
- busy_q is i_sb_busy delayed by one cycle. Busy falling edge = busy_q & !i_sb_busy.
- States: IDLE, GRANT, SENDING, RELEASE.
- IDLE:
  - If i_trainerror_en & !i_sb_busy & (i_tx_valid | i_rx_valid), grant and go to GRANT.
  - A single requester wins outright.
  - If both request, the one not equal to last_grant wins.
  - On grant: latch the winner's msg into o_sb_msg, set o_sb_valid=1, set o_grant_x=1, update last_grant.
  - Latency: request sampled at edge N gives o_sb_valid high after edge N.
- GRANT:
  - i_sb_busy=1 → SENDING.
  - Granted requester's valid drops before busy rises (abort) → o_sb_valid=0, grant=0, IDLE, no done pulse.
- SENDING:
  - o_sb_valid and o_sb_msg held.
  - On busy falling edge: o_sb_valid=0, o_x_done=1 for one cycle, grant cleared, → RELEASE.
- RELEASE:
  - Exactly one cycle; no new grant is made.
  - Requesters must drop valid in the cycle after their done pulse.
  - → IDLE.
- o_sb_msg holds its last value in IDLE; it changes only on grant. Reset value is 0.
- A non-granted requester's valid/msg changes are ignored until the next IDLE arbitration.
- Granted requester's msg changes after grant are ignored (latched copy used).
- i_trainerror_en=0 in any state, checked at every edge: next cycle IDLE, o_sb_valid=0, grants=0, no done pulse. last_grant is retained.
- Reset mid-transfer: same as reset (outputs 0 next edge).
- Busy already high in IDLE: no grant until busy is low.
- Busy falling edge while in IDLE/GRANT: ignored (no done).
- o_grant_tx and o_grant_rx are never both 1. o_tx_done and o_rx_done are never both 1.

Optional Feature:
TRAINERROR_ARB_TIMEOUT_EN
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to GRANT and increments each cycle in GRANT/SENDING.
  - When it reaches TIMEOUT_CYCLES: o_timeout pulses 1 cycle, o_sb_valid=0, grant cleared, no done pulse, → RELEASE.
  - Counter resets to 0.
- Undefined: no counter logic; o_timeout tied 0; GRANT/SENDING wait indefinitely.

Test Plan:
- TX only, i_tx_msg=4'hA, busy rises 2 cycles after o_sb_valid and falls 3 cycles later → o_sb_msg=A, o_grant_tx=1, o_tx_done single pulse one cycle after the busy falling edge, o_sb_valid low the same cycle, RELEASE 1 cycle then IDLE.
- Simultaneous tx(msg 4'h3)/rx(msg 4'hE) valid after reset → TX granted first (o_sb_msg=3). Next arbitration with both still valid grants RX (o_sb_msg=E). A third tie goes back to TX.
- i_sb_busy held high when rx_valid asserts → no o_sb_valid until busy low, then grant next cycle.
- i_trainerror_en dropped while in SENDING → next cycle o_sb_valid=0, grants 0, no done pulse; state IDLE.
- TX drops i_tx_valid in GRANT before busy rises → o_sb_valid=0 next cycle, no o_tx_done, pending rx then granted from IDLE.
- With TRAINERROR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, busy never rises → o_timeout pulse 8 cycles after grant, o_sb_valid=0, no done; without the macro o_sb_valid stays high for 100+ cycles and o_timeout=0.
